// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// Module   : game_pkg
// Purpose  : Shared state encoding and default game constants.
// Revision : 1.0 - initial release
// ============================================================================
package game_pkg;

    localparam int c_num_bricks  = 9;
    localparam int c_start_lives = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_WIN   = 3'd3,
        ST_LOSE  = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/frame_tick_sync.sv
`default_nettype none
// ============================================================================
// Module   : frame_tick_sync
// Purpose  : Two-flop synchronizer for the frame strobe plus rising-edge pulse.
// Revision : 1.0 - initial release
// ============================================================================
module frame_tick_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_frame_clk,
    output logic o_frame_tick
);

    logic r_sync1;
    logic r_sync2;
    logic r_sync2_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_sync2_d <= 1'b0;
        end else begin
            r_sync1   <= i_frame_clk;
            r_sync2   <= r_sync1;
            r_sync2_d <= r_sync2;
        end
    end

    assign o_frame_tick = r_sync2 & ~r_sync2_d;

endmodule
`default_nettype wire

// File: rtl/breakout_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : breakout_game_ctrl
// Purpose  : Breakout game flow: serve timing, brick mask, lives, win/lose.
// Revision : 1.0 - initial release
// ============================================================================
module breakout_game_ctrl
    import game_pkg::*;
#(
    parameter int NUM_BRICKS   = c_num_bricks,
    parameter int START_LIVES  = c_start_lives,
    parameter int SERVE_FRAMES = 60
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  frame_clk,
    input  logic                  start,
    input  logic                  hit_valid,
    input  logic [3:0]            hit_index,
    input  logic                  ball_lost,
    output logic [NUM_BRICKS-1:0] brick_exists,
    output logic [1:0]            lives,
    output logic                  ball_reset,
    output logic                  hit_ack,
    output logic                  did_win_game,
    output logic                  did_lose_game
);

    localparam int                 c_cnt_w      = $clog2(SERVE_FRAMES + 1);
    localparam logic [c_cnt_w-1:0] c_serve_last = c_cnt_w'(SERVE_FRAMES - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one    = c_cnt_w'(1);
    localparam logic [1:0]         c_lives_init = 2'(START_LIVES);

    state_t                  r_state;
    state_t                  w_next_state;
    logic [NUM_BRICKS-1:0]   r_bricks;
    logic [1:0]              r_lives;
    logic [c_cnt_w-1:0]      r_serve_cnt;
    logic                    r_hit_ack;
    logic                    r_did_win;
    logic                    r_did_lose;

    logic                    w_frame_tick;
    logic [NUM_BRICKS-1:0]   w_hit_mask;
    logic [NUM_BRICKS-1:0]   w_bricks_after_hit;
    logic                    w_hit_accept;
    logic                    w_clear_last;
    logic                    w_loss;
    logic                    w_serve_done;

    frame_tick_sync u_frame_tick_sync (
        .clk          (Clk),
        .rst          (Reset),
        .i_frame_clk  (frame_clk),
        .o_frame_tick (w_frame_tick)
    );

    // Out-of-range indices decode to an empty mask, so they ack without effect.
    always_comb begin
        w_hit_mask = '0;
        for (int i = 0; i < NUM_BRICKS; i++) begin
            w_hit_mask[i] = (32'(hit_index) == i);
        end
        w_hit_accept       = (r_state == ST_PLAY) && hit_valid;
        w_bricks_after_hit = w_hit_accept ? (r_bricks & ~w_hit_mask) : r_bricks;
        w_clear_last       = w_hit_accept && (|(r_bricks & w_hit_mask))
                             && (w_bricks_after_hit == '0);
        w_loss             = (r_state == ST_PLAY) && w_frame_tick && ball_lost
                             && !w_clear_last;
        w_serve_done       = (r_state == ST_SERVE) && w_frame_tick
                             && (r_serve_cnt == c_serve_last);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_next_state = ST_SERVE;
            ST_SERVE: if (w_serve_done) w_next_state = ST_PLAY;
            ST_PLAY: begin
                if (w_clear_last) begin
                    w_next_state = ST_WIN;
                end else if (w_loss) begin
                    w_next_state = (r_lives > 2'd1) ? ST_SERVE : ST_LOSE;
                end
            end
            ST_WIN:   if (start) w_next_state = ST_IDLE;
            ST_LOSE:  if (start) w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        ball_reset = (r_state != ST_PLAY);
    end

    // Reloading on entry to IDLE makes the fresh board visible in IDLE's first cycle.
    always_ff @(posedge Clk) begin
        if (Reset || (w_next_state == ST_IDLE)) begin
            r_bricks <= '1;
            r_lives  <= c_lives_init;
        end else if (r_state == ST_PLAY) begin
            r_bricks <= w_bricks_after_hit;
            if (w_loss && (r_lives != 2'd0)) begin
                r_lives <= r_lives - 2'd1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_serve_cnt <= '0;
            r_hit_ack   <= 1'b0;
            r_did_win   <= 1'b0;
            r_did_lose  <= 1'b0;
        end else begin
            r_hit_ack  <= w_hit_accept;
            r_did_win  <= (w_next_state == ST_WIN);
            r_did_lose <= (w_next_state == ST_LOSE);
            if (r_state != ST_SERVE) begin
                r_serve_cnt <= '0;
            end else if (w_frame_tick) begin
                r_serve_cnt <= w_serve_done ? '0 : (r_serve_cnt + c_cnt_one);
            end
        end
    end

    assign brick_exists  = r_bricks;
    assign lives         = r_lives;
    assign hit_ack       = r_hit_ack;
    assign did_win_game  = r_did_win;
    assign did_lose_game = r_did_lose;

endmodule
`default_nettype wire

// File: tb/tb_breakout_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_breakout_game_ctrl
// Purpose  : Directed plus random checks of breakout_game_ctrl against a game model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_breakout_game_ctrl;

    localparam int NB      = 9;
    localparam int LIVES0  = 3;
    localparam int SERVE_N = 60;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          frame_clk;
    logic          start;
    logic          hit_valid;
    logic [3:0]    hit_index;
    logic          ball_lost;
    logic [NB-1:0] brick_exists;
    logic [1:0]    lives;
    logic          ball_reset;
    logic          hit_ack;
    logic          did_win_game;
    logic          did_lose_game;

    int total = 0;
    int bad   = 0;

    string m_mode;
    bit    m_alive [NB];
    int    m_lives;
    int    m_ticks;

    breakout_game_ctrl #(
        .NUM_BRICKS   (NB),
        .START_LIVES  (LIVES0),
        .SERVE_FRAMES (SERVE_N)
    ) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .frame_clk     (frame_clk),
        .start         (start),
        .hit_valid     (hit_valid),
        .hit_index     (hit_index),
        .ball_lost     (ball_lost),
        .brick_exists  (brick_exists),
        .lives         (lives),
        .ball_reset    (ball_reset),
        .hit_ack       (hit_ack),
        .did_win_game  (did_win_game),
        .did_lose_game (did_lose_game)
    );

    always #5 Clk = ~Clk;

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic m_reset();
        m_mode = "IDLE";
        for (int i = 0; i < NB; i++) m_alive[i] = 1'b1;
        m_lives = LIVES0;
        m_ticks = 0;
    endtask

    function automatic int m_alive_count();
        int n = 0;
        for (int i = 0; i < NB; i++) n += int'(m_alive[i]);
        return n;
    endfunction

    function automatic logic [NB-1:0] m_mask();
        logic [NB-1:0] m;
        for (int i = 0; i < NB; i++) m[i] = m_alive[i];
        return m;
    endfunction

    task automatic m_start();
        if (m_mode == "IDLE") begin
            m_mode  = "SERVE";
            m_ticks = 0;
        end else if (m_mode == "WIN" || m_mode == "LOSE") begin
            m_reset();
        end
    endtask

    task automatic m_hit(input int idx, output bit ack);
        ack = 1'b0;
        if (m_mode == "PLAY") begin
            ack = 1'b1;
            if (idx < NB) m_alive[idx] = 1'b0;
            if (m_alive_count() == 0) m_mode = "WIN";
        end
    endtask

    // One frame tick, optionally with a hit landing in the same clock.
    task automatic m_frame(input bit bl, input bit hv, input int idx, output bit ack);
        ack = 1'b0;
        if (m_mode == "SERVE") begin
            m_ticks++;
            if (m_ticks == SERVE_N) begin
                m_mode  = "PLAY";
                m_ticks = 0;
            end
        end else if (m_mode == "PLAY") begin
            if (hv) m_hit(idx, ack);
            if (m_mode == "PLAY" && bl) begin
                if (m_lives > 1) begin
                    m_lives--;
                    m_mode  = "SERVE";
                    m_ticks = 0;
                end else begin
                    m_lives = 0;
                    m_mode  = "LOSE";
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_bricks"}, 32'(brick_exists), 32'(m_mask()));
        chk({tag, "_lives"}, 32'(lives), 32'(m_lives));
        chk({tag, "_ball_reset"}, 32'(ball_reset), 32'(m_mode != "PLAY"));
        chk({tag, "_win"}, 32'(did_win_game), 32'(m_mode == "WIN"));
        chk({tag, "_lose"}, 32'(did_lose_game), 32'(m_mode == "LOSE"));
        chk({tag, "_ack_idle"}, 32'(hit_ack), 32'd0);
    endtask

    task automatic start_pulse(input string tag);
        @(negedge Clk);
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        m_start();
        check_all(tag);
    endtask

    task automatic do_hit(input int idx, input string tag);
        bit ack;
        @(negedge Clk);
        hit_valid = 1'b1;
        hit_index = idx[3:0];
        @(negedge Clk);
        hit_valid = 1'b0;
        m_hit(idx, ack);
        chk({tag, "_ack"}, 32'(hit_ack), 32'(ack));
        @(negedge Clk);
        check_all(tag);
    endtask

    // Synchronized tick is live in the third clock after the rising edge.
    task automatic frame_pulse(input bit with_hit, input int idx, input string tag);
        bit ack;
        @(negedge Clk);
        frame_clk = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        if (with_hit) begin
            hit_valid = 1'b1;
            hit_index = idx[3:0];
        end
        @(negedge Clk);
        hit_valid = 1'b0;
        m_frame(ball_lost, with_hit, idx, ack);
        if (with_hit) chk({tag, "_tick_ack"}, 32'(hit_ack), 32'(ack));
        frame_clk = 1'b0;
        repeat (2) @(negedge Clk);
        check_all(tag);
    endtask

    task automatic serve(input int n, input string tag);
        for (int k = 0; k < n; k++) frame_pulse(1'b0, 0, tag);
    endtask

    initial begin
        int op;
        bit ack;
        Reset     = 1'b1;
        frame_clk = 1'b0;
        start     = 1'b0;
        hit_valid = 1'b0;
        hit_index = 4'd0;
        ball_lost = 1'b0;
        m_reset();
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        check_all("reset");

        start_pulse("start");
        do_hit(3, "hit_in_serve");
        start_pulse("start_in_serve");
        serve(SERVE_N - 1, "serve59");

        @(negedge Clk);
        frame_clk = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        chk("play_latency", 32'(ball_reset), 32'd0);
        @(negedge Clk);
        frame_clk = 1'b0;
        m_frame(1'b0, 1'b0, 0, ack);
        repeat (2) @(negedge Clk);
        check_all("in_play");

        start_pulse("start_in_play");
        for (int i = 0; i < NB; i++) do_hit(i, "clear_seq");

        start_pulse("win_to_idle");
        start_pulse("serve2");
        serve(SERVE_N, "serve2");
        do_hit(12, "hit_oob");
        do_hit(2, "hit_first");
        do_hit(2, "hit_repeat");

        ball_lost = 1'b1;
        do_hit(5, "loss_no_tick");
        frame_pulse(1'b0, 0, "loss1");
        serve(SERVE_N, "serve_l1");
        frame_pulse(1'b0, 0, "loss2");
        serve(SERVE_N, "serve_l2");
        frame_pulse(1'b0, 0, "loss3");
        frame_pulse(1'b0, 0, "loss4");
        ball_lost = 1'b0;

        start_pulse("lose_to_idle");
        start_pulse("serve3");
        serve(SERVE_N, "serve3");
        for (int i = 0; i < NB; i++) if (i != 4) do_hit(i, "leave4");
        ball_lost = 1'b1;
        frame_pulse(1'b1, 4, "win_vs_loss");
        ball_lost = 1'b0;

        start_pulse("idle4");
        start_pulse("serve4");
        serve(30, "serve_half");
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        m_reset();
        @(negedge Clk);
        check_all("reset_mid_serve");
        start_pulse("serve5");
        serve(SERVE_N - 1, "serve5");
        serve(1, "serve5_last");

        for (int n = 0; n < 150; n++) begin
            ball_lost = ($urandom_range(0, 3) == 0);
            if (m_mode == "SERVE") begin
                serve(SERVE_N - m_ticks, "rnd_serve");
            end else begin
                op = int'($urandom_range(0, 9));
                if (op < 5)      do_hit(int'($urandom_range(0, 15)), "rnd_hit");
                else if (op < 7) frame_pulse(1'b0, 0, "rnd_frame");
                else if (op < 9) frame_pulse(1'b1, int'($urandom_range(0, 15)), "rnd_frame_hit");
                else             start_pulse("rnd_start");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/breakout_game_ctrl.md
BREAKOUT_GAME_CTRL -- requirements
Module: breakout_game_ctrl

Interface
REQ-001 Parameter NUM_BRICKS, default 9: number of brick slots tracked.
REQ-002 Parameter START_LIVES, default 3: lives loaded at game start.
REQ-003 Parameter SERVE_FRAMES, default 60: frame ticks spent in SERVE before play resumes.
REQ-004 Clk  in  1: sole clock; all state updates on rising edge.
REQ-005 Reset  in  1: synchronous, active-high reset.
REQ-006 frame_clk  in  1: vertical-sync-rate strobe, asynchronous to Clk.
REQ-007 start  in  1: one-Clk pulse from the keyboard path requesting a new game.
REQ-008 hit_valid  in  1: collision logic reports a brick hit this cycle.
REQ-009 hit_index  in  4: brick slot hit; valid only with hit_valid.
REQ-010 ball_lost  in  1: level signal, ball below the paddle line.
REQ-011 brick_exists  out  NUM_BRICKS: per-brick alive mask to the color mapper.
REQ-012 lives  out  2: remaining lives.
REQ-013 ball_reset  out  1: high while the ball must be held at serve position.
REQ-014 hit_ack  out  1: one-cycle pulse acknowledging a processed hit.
REQ-015 did_win_game, did_lose_game  out  1 each: end-of-game flags to the color mapper.

Function
REQ-016 frame_clk SHALL pass a 2-flop synchronizer; a rising edge of the synchronized signal SHALL produce a one-Clk frame_tick.
REQ-017 FSM states SHALL be IDLE, SERVE, PLAY, WIN and LOSE.
REQ-018 IDLE: brick_exists all ones, lives = START_LIVES, ball_reset = 1; start -> SERVE.
REQ-019 SERVE: ball_reset = 1; a serve counter SHALL count frame_ticks; on the SERVE_FRAMES-th tick -> PLAY and the counter SHALL clear.
REQ-020 PLAY: ball_reset = 0; hits and ball losses SHALL be processed only in this state.
REQ-021 A hit with hit_index < NUM_BRICKS SHALL clear brick_exists[hit_index] on the next Clk edge.
REQ-022 hit_ack SHALL pulse exactly one cycle after every hit_valid accepted in PLAY, including out-of-range or already-cleared indices, which change nothing.
REQ-023 hit_valid outside PLAY SHALL be ignored, with no hit_ack.
REQ-024 When brick_exists becomes all zeros, the FSM SHALL enter WIN on the same edge that clears the last brick.
REQ-025 Ball loss SHALL be sampled only on frame_tick in PLAY.
  - If lives > 1: decrement lives, go to SERVE.
  - If lives == 1: set lives to 0, go to LOSE.
REQ-026 If the last-brick hit and a sampled ball loss occur in the same cycle, WIN SHALL take priority and lives SHALL be unchanged.
REQ-027 did_win_game SHALL be 1 only in WIN, and did_lose_game SHALL be 1 only in LOSE; both SHALL be registered outputs.
REQ-028 In WIN or LOSE, ball_reset = 1 and brick_exists and lives SHALL hold; start -> IDLE.
REQ-029 start SHALL be ignored in SERVE and PLAY.
REQ-030 The lives counter SHALL never wrap below 0.

Reset
REQ-031 Reset SHALL force IDLE, brick_exists = all ones, lives = START_LIVES, and ball_reset = 1.
REQ-032 Reset SHALL clear hit_ack, did_win_game, did_lose_game, the serve counter and the synchronizer flops.
REQ-033 Reset SHALL override every other input in any state, including mid-SERVE count.

Structure
REQ-034 The state enum and the NUM_BRICKS and START_LIVES constants SHALL live in a shared package, game_pkg.
REQ-035 The synchronizer and edge detector SHALL be one sub-module, frame_tick_sync.

Verification
REQ-036 Reset, then start, then 60 frame_clk edges -> ball_reset falls and the FSM is in PLAY within 3 Clk of the 60th synchronized edge.
REQ-037 In PLAY, hits on indices 0..8 in order -> brick_exists steps from 0x1FF down to 0x000, hit_ack pulses 9 times, and did_win_game = 1 after the 9th hit.
REQ-038 In PLAY, hold ball_lost across 3 frame ticks with serves between -> lives goes 3->2->1->0 and did_lose_game = 1; a 4th loss does not change lives.
REQ-039 With only brick 4 left, hit_index = 4 coincident with a sampled ball loss -> WIN, lives unchanged.
REQ-040 In PLAY, hit_index = 12 and then a repeated index 2 -> each gets a hit_ack with no mask change; hit_valid in SERVE -> no ack.
REQ-041 Reset asserted at serve count 30 -> IDLE, and start then requires the full 60 ticks again.
